// File: rtl/fsm_pantalla_pkg.sv
// Shared constants for the screen-edit controller and the character generator.
// Group codes, button bit indices and small group-decoding helpers.
package fsm_pantalla_pkg;

  localparam logic [1:0] EDIT_NONE  = 2'd0;
  localparam logic [1:0] EDIT_TIMER = 2'd1;
  localparam logic [1:0] EDIT_FECHA = 2'd2;
  localparam logic [1:0] EDIT_HORA  = 2'd3;

  localparam int unsigned BTN_OK     = 0;
  localparam int unsigned BTN_NEXT   = 1;
  localparam int unsigned BTN_PREV   = 2;
  localparam int unsigned BTN_CANCEL = 3;

  typedef enum logic [0:0] {StIdle, StEdit} state_e;

  // sw is packed as {timer, fecha, hora}; hora has the highest priority.
  function automatic logic [1:0] pick_group(logic [2:0] sw);
    logic [1:0] grp;
    grp = EDIT_NONE;
    if (sw[0]) begin
      grp = EDIT_HORA;
    end else if (sw[1]) begin
      grp = EDIT_FECHA;
    end else if (sw[2]) begin
      grp = EDIT_TIMER;
    end
    return grp;
  endfunction

  function automatic logic group_sw(logic [1:0] grp, logic [2:0] sw);
    logic on;
    on = 1'b0;
    case (grp)
      EDIT_TIMER: on = sw[2];
      EDIT_FECHA: on = sw[1];
      EDIT_HORA:  on = sw[0];
      default:    on = 1'b0;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/fsm_pantalla_btn_edge.sv
// Rising-edge detector for the edit buttons.
// History resets to all ones so a button held through reset is not a press.
module fsm_pantalla_btn_edge #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= '1;
    end else begin
      btn_q <= btn;
    end
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/fsm_pantalla.sv
// Screen-edit controller: selects the edited field group and the active
// two-digit position inside it, and registers the mode switches.
module fsm_pantalla
  import fsm_pantalla_pkg::*;
#(
  parameter int unsigned NUM_POS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_timer,
  input  logic       sw_fecha,
  input  logic       sw_hora,
  input  logic [3:0] boton_ed,
  output logic [1:0] FSMedit,
  output logic [1:0] FSMpos,
  output logic [2:0] switches
);

  localparam logic [1:0] PosMax = 2'(NUM_POS);

  logic [2:0] sw;
  logic [3:0] rise;
  state_e     state_q, state_d;
  logic [1:0] grp_q, grp_d;
  logic [1:0] pos_q, pos_d;
  logic [2:0] sw_q;

  assign sw = {sw_timer, sw_fecha, sw_hora};

  fsm_pantalla_btn_edge #(
    .WIDTH(4)
  ) u_btn_edge (
    .clk  (clk),
    .reset(reset),
    .btn  (boton_ed),
    .rise (rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grp_q   <= EDIT_NONE;
      pos_q   <= 2'd0;
      sw_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      pos_q   <= pos_d;
      sw_q    <= sw;
    end
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    pos_d   = pos_q;
    unique case (state_q)
      StIdle: begin
        if (rise[BTN_OK] && (sw != 3'b000)) begin
          state_d = StEdit;
          grp_d   = pick_group(sw);
          pos_d   = 2'd1;
        end
      end
      StEdit: begin
        // Exit conditions outrank any position movement in the same cycle.
        if (!group_sw(grp_q, sw) || rise[BTN_OK] || rise[BTN_CANCEL]) begin
          state_d = StIdle;
          grp_d   = EDIT_NONE;
          pos_d   = 2'd0;
        end else if (rise[BTN_NEXT]) begin
          pos_d = (pos_q >= PosMax) ? 2'd1 : pos_q + 2'd1;
        end else if (rise[BTN_PREV]) begin
          pos_d = (pos_q <= 2'd1) ? PosMax : pos_q - 2'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grp_d   = EDIT_NONE;
        pos_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    FSMedit  = (state_q == StEdit) ? grp_q : EDIT_NONE;
    FSMpos   = (state_q == StEdit) ? pos_q : 2'd0;
    switches = sw_q;
  end

endmodule

// File: tb/tb_fsm_pantalla.sv
// Self-checking bench for fsm_pantalla: one-cycle vector table plus
// hand-written multi-cycle sequences, compared through a scoreboard queue.
module tb_fsm_pantalla;

  logic       clk;
  logic       reset;
  logic       sw_timer, sw_fecha, sw_hora;
  logic [3:0] boton_ed;
  logic [1:0] FSMedit;
  logic [1:0] FSMpos;
  logic [2:0] switches;

  typedef struct {
    logic [2:0] sw;
    logic [3:0] btn;
    logic [1:0] edit;
    logic [1:0] pos;
    string      name;
  } vec_t;

  typedef struct {
    logic [1:0] edit;
    logic [1:0] pos;
    logic [2:0] sw;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  fsm_pantalla #(
    .NUM_POS(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_timer(sw_timer),
    .sw_fecha(sw_fecha),
    .sw_hora (sw_hora),
    .boton_ed(boton_ed),
    .FSMedit (FSMedit),
    .FSMpos  (FSMpos),
    .switches(switches)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  function automatic void add(logic [2:0] sw, logic [3:0] btn, logic [1:0] e, logic [1:0] p,
                              string name);
    vec_t v;
    v.sw = sw; v.btn = btn; v.edit = e; v.pos = p; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // sw is {timer, fecha, hora}; one call is one clock cycle.
  task automatic step(logic rst, logic [2:0] sw, logic [3:0] btn, logic [1:0] e_edit,
                      logic [1:0] e_pos, logic [2:0] e_sw, string name);
    exp_t x;
    @(negedge clk);
    reset = rst;
    {sw_timer, sw_fecha, sw_hora} = sw;
    boton_ed = btn;
    x.edit = e_edit; x.pos = e_pos; x.sw = e_sw; x.name = name;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({x.name, ".FSMedit"}, int'(FSMedit), int'(x.edit));
    check({x.name, ".FSMpos"}, int'(FSMpos), int'(x.pos));
    check({x.name, ".switches"}, int'(switches), int'(x.sw));
  endtask

  initial begin
    reset = 1'b1;
    {sw_timer, sw_fecha, sw_hora} = 3'b001;
    boton_ed = 4'b0001;

    add(3'b001, 4'b0001, 2'd0, 2'd0, "ok_held_through_reset");
    add(3'b001, 4'b0000, 2'd0, 2'd0, "ok_released");
    add(3'b001, 4'b0001, 2'd3, 2'd1, "enter_hora");
    add(3'b001, 4'b0000, 2'd3, 2'd1, "idle_in_edit");
    add(3'b001, 4'b0010, 2'd3, 2'd2, "next1");
    add(3'b001, 4'b0000, 2'd3, 2'd2, "rel");
    add(3'b001, 4'b0010, 2'd3, 2'd3, "next2");
    add(3'b001, 4'b0000, 2'd3, 2'd3, "rel");
    add(3'b001, 4'b0010, 2'd3, 2'd1, "next3_wrap");
    add(3'b001, 4'b0000, 2'd3, 2'd1, "rel");
    add(3'b001, 4'b0010, 2'd3, 2'd2, "next4");
    add(3'b001, 4'b0000, 2'd3, 2'd2, "rel");
    add(3'b001, 4'b0100, 2'd3, 2'd1, "prev1");
    add(3'b001, 4'b0000, 2'd3, 2'd1, "rel");
    add(3'b001, 4'b0100, 2'd3, 2'd3, "prev2_wrap");
    add(3'b001, 4'b0000, 2'd3, 2'd3, "rel");
    add(3'b001, 4'b0001, 2'd0, 2'd0, "confirm_exit");
    add(3'b001, 4'b0000, 2'd0, 2'd0, "rel");
    add(3'b011, 4'b0001, 2'd3, 2'd1, "hora_over_fecha");
    add(3'b011, 4'b0000, 2'd3, 2'd1, "rel");
    add(3'b011, 4'b1000, 2'd0, 2'd0, "cancel_exit");
    add(3'b010, 4'b0000, 2'd0, 2'd0, "rel");
    add(3'b010, 4'b0001, 2'd2, 2'd1, "enter_fecha");
    add(3'b000, 4'b0000, 2'd0, 2'd0, "fecha_drop");
    add(3'b100, 4'b0001, 2'd1, 2'd1, "enter_timer");
    add(3'b101, 4'b0000, 2'd1, 2'd1, "other_sw_rise");
    add(3'b100, 4'b0000, 2'd1, 2'd1, "other_sw_fall");
    add(3'b100, 4'b0010, 2'd1, 2'd2, "timer_next");
    add(3'b000, 4'b0000, 2'd0, 2'd0, "timer_drop");
    add(3'b101, 4'b0010, 2'd0, 2'd0, "idle_next_ignored");
    add(3'b101, 4'b0000, 2'd0, 2'd0, "rel");
    add(3'b101, 4'b0100, 2'd0, 2'd0, "idle_prev_ignored");
    add(3'b101, 4'b1000, 2'd0, 2'd0, "idle_cancel_ignored");
    add(3'b000, 4'b0000, 2'd0, 2'd0, "rel");
    add(3'b000, 4'b0001, 2'd0, 2'd0, "ok_no_switch");
    add(3'b000, 4'b0000, 2'd0, 2'd0, "rel");

    step(1'b1, 3'b001, 4'b0001, 2'd0, 2'd0, 3'b000, "reset_a");
    step(1'b1, 3'b001, 4'b0001, 2'd0, 2'd0, 3'b000, "reset_b");
    foreach (vecs[i]) begin
      step(1'b0, vecs[i].sw, vecs[i].btn, vecs[i].edit, vecs[i].pos, vecs[i].sw, vecs[i].name);
    end

    // Holding next for ten cycles advances exactly once.
    step(1'b0, 3'b001, 4'b0001, 2'd3, 2'd1, 3'b001, "hold_enter");
    step(1'b0, 3'b001, 4'b0000, 2'd3, 2'd1, 3'b001, "hold_rel");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'b001, 4'b0010, 2'd3, 2'd2, 3'b001, "hold_next");
    end
    step(1'b0, 3'b001, 4'b0000, 2'd3, 2'd2, 3'b001, "hold_rel2");
    step(1'b0, 3'b000, 4'b0000, 2'd0, 2'd0, 3'b000, "hora_drop_pos2");

    // Cancel from position 2.
    step(1'b0, 3'b001, 4'b0001, 2'd3, 2'd1, 3'b001, "enter2");
    step(1'b0, 3'b001, 4'b0010, 2'd3, 2'd2, 3'b001, "next_to2");
    step(1'b0, 3'b001, 4'b1000, 2'd0, 2'd0, 3'b001, "cancel_pos2");
    step(1'b0, 3'b001, 4'b0000, 2'd0, 2'd0, 3'b001, "rel");

    // Simultaneous presses: exit over next, next over prev.
    step(1'b0, 3'b001, 4'b0001, 2'd3, 2'd1, 3'b001, "enter3");
    step(1'b0, 3'b001, 4'b0110, 2'd3, 2'd2, 3'b001, "next_beats_prev");
    step(1'b0, 3'b001, 4'b0000, 2'd3, 2'd2, 3'b001, "rel");
    step(1'b0, 3'b001, 4'b0011, 2'd0, 2'd0, 3'b001, "ok_beats_next");
    step(1'b0, 3'b001, 4'b0000, 2'd0, 2'd0, 3'b001, "rel");

    // Reset mid-edit clears on the same edge.
    step(1'b0, 3'b001, 4'b0001, 2'd3, 2'd1, 3'b001, "enter4");
    step(1'b0, 3'b001, 4'b0000, 2'd3, 2'd1, 3'b001, "rel");
    step(1'b1, 3'b001, 4'b0000, 2'd0, 2'd0, 3'b000, "reset_mid_edit");
    step(1'b0, 3'b001, 4'b0000, 2'd0, 2'd0, 3'b001, "after_reset");
    step(1'b0, 3'b001, 4'b0001, 2'd3, 2'd1, 3'b001, "reenter");

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_pantalla.md
Name: fsm_pantalla

Overview:
Screen-edit controller for the VGA RTC display. It selects which clock field group is being edited (hora, fecha or timer) and which two-digit position inside that group is active. Its outputs drive the character generator's edit highlighting and its choice between live RTC digits and edit-buffer digits. It also presents the registered mode switches to the rest of the design.

Parameters:
NUM_POS, 3, number of editable positions per group; positions are numbered 1..NUM_POS and NUM_POS must be ≤3 to fit FSMpos.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
sw_timer  in  1  timer group select switch (level).
sw_fecha  in  1  date group select switch (level).
sw_hora  in  1  time group select switch (level).
boton_ed  in  4  edit buttons (levels): [0] enter/confirm, [1] next position, [2] previous position, [3] cancel.
FSMedit  out  2  active edit group: 0 none, 1 timer, 2 fecha, 3 hora.
FSMpos  out  2  active position: 0 when not editing, otherwise 1..NUM_POS.
switches  out  3  registered copy of {sw_timer, sw_fecha, sw_hora}.

Behaviour:
- Reset values:
  - FSMedit=0, FSMpos=0, switches=0.
  - Button history register btn_q=4'b1111, so a button already held when reset releases is not seen as a press.
- Edge detection:
  - rise = boton_ed & ~btn_q; btn_q <= boton_ed every cycle.
  - Each press acts exactly once, in the cycle where rise is 1.
- Latency: outputs are registered. A state change becomes visible on the clock edge at which rise is first seen.
- switches <= {sw_timer, sw_fecha, sw_hora} every cycle (1-cycle latency).
- IDLE state (FSMedit=0):
  - On rise[0], enter the group of the highest-priority active switch: hora (3) > fecha (2) > timer (1). Set FSMpos=1.
  - If no switch is active, stay in IDLE.
  - rise[1], rise[2] and rise[3] are ignored in IDLE.
- EDIT state (FSMedit≠0):
  - rise[0] (confirm) or rise[3] (cancel) → IDLE; FSMedit=0, FSMpos=0.
  - rise[1] → FSMpos+1; wraps from NUM_POS to 1.
  - rise[2] → FSMpos−1; wraps from 1 to NUM_POS.
  - If the current group's switch deasserts → IDLE at the next edge.
  - Other switches changing while editing do not change FSMedit.
- Simultaneous events, in priority order:
  - 1. reset
  - 2. switch deassert / rise[0] / rise[3] (exit)
  - 3. rise[1]
  - 4. rise[2]
- FSMpos is never 0 while FSMedit≠0, and always 0 while FSMedit=0.
- Reset asserted mid-edit returns to IDLE on the same edge.

Decomposition:
- Shared package constants:
  - EDIT_NONE=0, EDIT_TIMER=1, EDIT_FECHA=2, EDIT_HORA=3.
  - Button bit indices BTN_OK=0, BTN_NEXT=1, BTN_PREV=2, BTN_CANCEL=3.
- These constants are also used by the character generator.
- One natural sub-module: btn_edge, a 4-bit rising-edge detector with reset-to-ones history.
- The position counter stays inline.

Test Plan:
- Reset with boton_ed=4'b0001 held, then released and pressed again → no change until the second press; FSMedit=3, FSMpos=1 when sw_hora=1.
- sw_fecha=1, sw_hora=1, press boton_ed[0] → FSMedit=3 (hora priority). With only sw_timer=1 → FSMedit=1, FSMpos=1.
- In edit, press [1] four times → FSMpos 2,3,1,2. Then press [2] twice → 1,3.
- Hold boton_ed[1] high for 10 cycles → FSMpos advances exactly once.
- In hora edit at FSMpos=2, drop sw_hora → next edge FSMedit=0, FSMpos=0. Repeat with a [3] press → same result. Assert [0] and [1] together → exit wins.
- switches tracks {sw_timer, sw_fecha, sw_hora}=3'b101 one cycle later. Pressing boton_ed[1] in IDLE leaves FSMedit=0, FSMpos=0.
